// File: rtl/elink_frame_deserializer.sv
// elink_frame_deserializer
// Receive-side e-link packet decoder. Consumes comma / SOP / 10 payload bytes
// / EOP symbols and rebuilds the 76-bit CAN frame. Malformed or stalled
// packets are discarded and reported with a one-cycle error strobe.
module elink_frame_deserializer #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_in,
  input  logic [1:0]  delimiter_in,
  input  logic        symbol_valid,
  input  logic [7:0]  Kchar_sop,
  input  logic [7:0]  Kchar_eop,
  input  logic [7:0]  Kchar_comma,
  output logic [75:0] data_frame_out,
  output logic        frame_valid,
  output logic        frame_error,
  output logic        busy
);

  localparam logic [1:0] DLM_PAY   = 2'b00;
  localparam logic [1:0] DLM_EOP   = 2'b01;
  localparam logic [1:0] DLM_SOP   = 2'b10;
  localparam logic [1:0] DLM_COMMA = 2'b11;

  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);
  localparam bit               WDOG_EN     = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PAYLOAD  = 2'd1,
    WAIT_EOP = 2'd2
  } state_t;

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic [CNT_W-1:0] r_wdog;
  logic [75:0]      r_shift;
  logic [75:0]      r_frame;
  logic             r_fvalid;
  logic             r_ferror;
  logic             r_busy;

  state_t           w_state_nx;
  logic [3:0]       w_cnt_nx;
  logic [CNT_W-1:0] w_wdog_nx;
  logic [CNT_W-1:0] w_wdog_inc;
  logic [75:0]      w_shift_nx;
  logic [75:0]      w_frame_nx;
  logic             w_fvalid_nx;
  logic             w_ferror_nx;
  logic             w_kchar_ok;
  logic             w_timeout;

  assign data_frame_out = r_frame;
  assign frame_valid    = r_fvalid;
  assign frame_error    = r_ferror;
  assign busy           = r_busy;

  assign w_wdog_inc = r_wdog + CNT_W'(1);
  // Timeout fires only on a cycle with no symbol: an arriving symbol wins.
  assign w_timeout  = WDOG_EN && (r_state != IDLE) && !symbol_valid &&
                      (w_wdog_inc == TIMEOUT_LIM);

  // K-character check: every delimiter class except payload names its byte.
  always_comb begin
    w_kchar_ok = 1'b1;
    case (delimiter_in)
      DLM_SOP:   w_kchar_ok = (data_in == Kchar_sop);
      DLM_EOP:   w_kchar_ok = (data_in == Kchar_eop);
      DLM_COMMA: w_kchar_ok = (data_in == Kchar_comma);
      default:   w_kchar_ok = 1'b1;
    endcase
  end

  // Next-state, datapath and strobe decode.
  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_wdog_nx   = '0;
    w_shift_nx  = r_shift;
    w_frame_nx  = r_frame;
    w_fvalid_nx = 1'b0;
    w_ferror_nx = 1'b0;

    if (r_state == IDLE) begin
      // Anything but a well-formed SOP is silently dropped while idle.
      if (symbol_valid && delimiter_in == DLM_SOP && w_kchar_ok) begin
        w_state_nx = PAYLOAD;
        w_cnt_nx   = '0;
        w_shift_nx = '0;
      end
    end else if (symbol_valid) begin
      if (!w_kchar_ok) begin
        w_ferror_nx = 1'b1;
        w_state_nx  = IDLE;
        w_cnt_nx    = '0;
      end else begin
        case (delimiter_in)
          DLM_SOP: begin
            // Abort the open packet and start over on the new SOP.
            w_ferror_nx = 1'b1;
            w_state_nx  = PAYLOAD;
            w_cnt_nx    = '0;
            w_shift_nx  = '0;
          end
          DLM_PAY: begin
            if (r_state == PAYLOAD) begin
              // Bytes 0..8 carry full octets, byte 9 only its upper nibble.
              if (r_cnt == 4'd9) begin
                w_shift_nx = {r_shift[71:0], data_in[7:4]};
                w_state_nx = WAIT_EOP;
              end else begin
                w_shift_nx = {r_shift[67:0], data_in};
              end
              w_cnt_nx = r_cnt + 4'd1;
            end else begin
              w_ferror_nx = 1'b1;
              w_state_nx  = IDLE;
              w_cnt_nx    = '0;
            end
          end
          DLM_EOP: begin
            if (r_state == WAIT_EOP) begin
              w_frame_nx  = r_shift;
              w_fvalid_nx = 1'b1;
            end else begin
              w_ferror_nx = 1'b1;
            end
            w_state_nx = IDLE;
            w_cnt_nx   = '0;
          end
          default: begin
            // Comma inside a packet is idle fill.
          end
        endcase
      end
    end else if (w_timeout) begin
      w_ferror_nx = 1'b1;
      w_state_nx  = IDLE;
      w_cnt_nx    = '0;
    end else begin
      w_wdog_nx = w_wdog_inc;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_wdog   <= '0;
      r_shift  <= '0;
      r_frame  <= '0;
      r_fvalid <= 1'b0;
      r_ferror <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_wdog   <= w_wdog_nx;
      r_shift  <= w_shift_nx;
      r_frame  <= w_frame_nx;
      r_fvalid <= w_fvalid_nx;
      r_ferror <= w_ferror_nx;
      r_busy   <= (w_state_nx != IDLE);
    end
  end

endmodule

// File: doc/elink_frame_deserializer.md
Name: elink_frame_deserializer

Overview:
- Receive-side counterpart of the e-link byte serializer.
- Consumes the 8-bit symbol stream plus its 2-bit delimiter code (comma, SOP, 10 payload bytes, EOP) and reassembles the 76-bit CAN frame.
- Sits between the e-link de-framer and the MOPS-Hub CAN request path; presents one frame per valid packet with a single-cycle strobe.
- Flags malformed packets and stalled packets.

Parameters:
- TIMEOUT_CYCLES, 1024: max clk cycles between accepted symbols while a packet is open; 0 disables the watchdog.
- CNT_W, 16: width of the watchdog counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous active-low reset
- data_in  in  8  received symbol byte
- delimiter_in  in  2  symbol class: 11 comma/idle, 10 SOP, 00 payload, 01 EOP
- symbol_valid  in  1  data_in/delimiter_in qualified this cycle
- Kchar_sop  in  8  expected SOP K-character
- Kchar_eop  in  8  expected EOP K-character
- Kchar_comma  in  8  expected comma K-character
- data_frame_out  out  76  last good frame, held until the next good frame
- frame_valid  out  1  one-cycle strobe, data_frame_out updated
- frame_error  out  1  one-cycle strobe, packet discarded
- busy  out  1  high while a packet is open (state != IDLE)

Behaviour:
- Reset, asynchronous while rst=0: data_frame_out=0, frame_valid=0, frame_error=0, busy=0, state=IDLE, byte counter=0, watchdog=0, shift register=0.
- Only cycles with symbol_valid=1 are symbols; all other cycles are ignored except by the watchdog.
- All outputs are registered. frame_valid and frame_error assert in the cycle after the EOP or the error symbol is sampled, for exactly one cycle. They are never asserted together.
- States are IDLE, PAYLOAD and WAIT_EOP.
- K-char check:
  - delimiter 10 requires data_in==Kchar_sop.
  - delimiter 01 requires data_in==Kchar_eop.
  - delimiter 11 requires data_in==Kchar_comma.
  - A mismatch in PAYLOAD or WAIT_EOP is an error. A mismatch in IDLE is ignored with no strobe.
- IDLE:
  - Comma or payload symbols are discarded.
  - EOP is discarded with no strobe.
  - A valid SOP clears the counter and moves to PAYLOAD.
- PAYLOAD:
  - Each payload byte shifts into the shift register and increments the counter.
  - Bytes 0..8 fill frame bits [75:4] MSB-first. Byte 9 supplies bits [3:0] from data_in[7:4]; data_in[3:0] is ignored.
  - After byte 9 (counter=10), go to WAIT_EOP.
  - Comma symbols are tolerated: no shift, no state change.
  - EOP with counter<10 is an error (short packet) and returns to IDLE.
- WAIT_EOP:
  - A valid EOP loads data_frame_out from the shift register, pulses frame_valid and returns to IDLE.
  - A payload byte is an error (long packet) and returns to IDLE.
  - Comma is tolerated.
- SOP in PAYLOAD or WAIT_EOP: pulse frame_error for the aborted packet, then restart. Counter cleared, state PAYLOAD, the new SOP is consumed.
- Watchdog:
  - Counts clk cycles with no symbol_valid while busy=1; it is cleared by any valid symbol and held at 0 in IDLE.
  - Reaching TIMEOUT_CYCLES pulses frame_error and returns to IDLE.
  - If symbol_valid arrives in the same cycle the timeout would fire, the symbol wins and the watchdog clears.
- On any error, data_frame_out keeps the previous good frame.
- Back-to-back packets (EOP immediately followed by SOP) must be accepted with no idle cycle.
- Reset asserted mid-packet discards the packet with no strobe.

Test Plan:
- Nominal packet: comma, SOP, bytes 0x12,0x34,0x56,0x78,0x9A,0xBC,0xDE,0xF0,0x11,0x2F, EOP -> one cycle after EOP, data_frame_out=76'h123456789ABCDEF0112 and frame_valid=1 for 1 cycle; busy low afterwards.
- Short packet: SOP, 5 payload bytes, EOP -> frame_error pulse, frame_valid never set, data_frame_out unchanged.
- Long packet and gaps:
  - SOP, 11 payload bytes -> frame_error on the 11th byte.
  - Same nominal packet with commas and symbol_valid gaps interleaved -> identical frame.
- SOP restart: SOP, 4 bytes, SOP, 10 bytes, EOP -> one frame_error pulse, then a frame_valid carrying the second packet only.
- Watchdog (TIMEOUT_CYCLES=8): SOP, 3 bytes, then symbol_valid=0 -> frame_error exactly 8 cycles after the last symbol; a symbol arriving on cycle 8 prevents the error.
- Reset and K-char checks:
  - rst low mid-packet -> all outputs 0 asynchronously; the following nominal packet decodes correctly.
  - delimiter 01 with data_in != Kchar_eop in WAIT_EOP -> frame_error.
